game_ctrl: RTL and testbench

- Parametrised match controller for the two-player fighting game; the next generation of the top-level game state logic.
- Sequences IDLE -> INTRO -> FIGHT -> ROUND_END -> ... -> GAME_OVER, with timed phases driven by a frame tick.
- Latches a play mode per match: PvP, PvAI or AIvAI. Muxes human or AI (random, hold-filtered) controls to each player.
- Counts round wins per player and reports the match winner. Sits between input/GPIO decoding and the two player instances.

---
 rtl/game_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_game_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Match controller for the two-player fighting game.
// Walks IDLE -> INTRO -> FIGHT -> ROUND_END -> ... -> GAME_OVER on frame ticks.
// Latches the play mode for each match and routes human or AI controls to each player.
// Counts round wins and reports the match winner.
// The random-bit port is named rand_bits because "rand" is a reserved word in SystemVerilog.
module game_ctrl #(
  parameter int SCORE_W         = 4,
  parameter int ROUNDS_TO_WIN   = 3,
  parameter int CNT_W           = 8,
  parameter int INTRO_TICKS     = 180,
  parameter int ROUND_END_TICKS = 120,
  parameter int AI_HOLD         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [2:0]         p1_btn,
  input  logic [2:0]         p2_btn,
  input  logic [5:0]         rand_bits,
  input  logic               p1_ko,
  input  logic               p2_ko,
  output logic [2:0]         p1_ctrl,
  output logic [2:0]         p2_ctrl,
  output logic               players_rst,
  output logic [2:0]         state,
  output logic [1:0]         mode_q,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner
);

  localparam int HOLD_W = (AI_HOLD > 1) ? $clog2(AI_HOLD) : 1;

  localparam logic [CNT_W-1:0]   INTRO_LAST     = CNT_W'(INTRO_TICKS - 1);
  localparam logic [CNT_W-1:0]   ROUND_END_LAST = CNT_W'(ROUND_END_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST      = HOLD_W'(AI_HOLD - 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE      = SCORE_W'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INTRO     = 3'd1,
    FIGHT     = 3'd2,
    ROUND_END = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [2:0]           ai1_q, ai1_d;
  logic [2:0]           ai2_q, ai2_d;
  logic [1:0]           mode_d;
  logic [SCORE_W-1:0]   p1_score_d, p2_score_d;
  logic [1:0]           winner_d;

  // An AI sample asking for left and right at once is meaningless, so drop both directions
  function automatic logic [2:0] filter_ai(input logic [2:0] s);
    if (s[1:0] == 2'b11) begin
      filter_ai = {s[2], 2'b00};
    end else begin
      filter_ai = s;
    end
  endfunction

  assign state = state_q;

  // Register every piece of match state; reset returns the whole controller to a clean IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      ai1_q    <= '0;
      ai2_q    <= '0;
      mode_q   <= '0;
      p1_score <= '0;
      p2_score <= '0;
      winner   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      ai1_q    <= ai1_d;
      ai2_q    <= ai2_d;
      mode_q   <= mode_d;
      p1_score <= p1_score_d;
      p2_score <= p2_score_d;
      winner   <= winner_d;
    end
  end

  // Next-state logic: abort overrides everything, otherwise each phase advances on its tick budget
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    ai1_d      = ai1_q;
    ai2_d      = ai2_q;
    mode_d     = mode_q;
    p1_score_d = p1_score;
    p2_score_d = p2_score;
    winner_d   = winner;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, GAME_OVER: begin
          if (start) begin
            mode_d     = (mode == 2'd3) ? 2'd1 : mode;
            p1_score_d = '0;
            p2_score_d = '0;
            winner_d   = '0;
            cnt_d      = '0;
            state_d    = INTRO;
          end
        end

        INTRO: begin
          if (tick) begin
            if (cnt_q == INTRO_LAST) begin
              cnt_d   = '0;
              hold_d  = '0;
              ai1_d   = '0;
              ai2_d   = '0;
              state_d = FIGHT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        FIGHT: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d = '0;
              ai1_d  = filter_ai(rand_bits[2:0]);
              ai2_d  = filter_ai(rand_bits[5:3]);
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          if (p1_ko || p2_ko) begin
            if (p2_ko && !p1_ko && (p1_score < WIN_SCORE)) begin
              p1_score_d = p1_score + SCORE_W'(1);
            end
            if (p1_ko && !p2_ko && (p2_score < WIN_SCORE)) begin
              p2_score_d = p2_score + SCORE_W'(1);
            end
            cnt_d   = '0;
            state_d = ROUND_END;
          end
        end

        ROUND_END: begin
          if (tick) begin
            if (cnt_q == ROUND_END_LAST) begin
              if (p1_score == WIN_SCORE) begin
                winner_d = 2'd1;
                state_d  = GAME_OVER;
              end else if (p2_score == WIN_SCORE) begin
                winner_d = 2'd2;
                state_d  = GAME_OVER;
              end else begin
                cnt_d   = '0;
                state_d = INTRO;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Player-facing decode: controls only flow during FIGHT, players are held in reset between bouts
  always_comb begin
    p1_ctrl     = 3'b000;
    p2_ctrl     = 3'b000;
    players_rst = 1'b1;
    case (state_q)
      FIGHT: begin
        players_rst = 1'b0;
        p1_ctrl     = (mode_q == 2'd2) ? ai1_q : p1_btn;
        p2_ctrl     = (mode_q == 2'd0) ? p2_btn : ai2_q;
      end
      GAME_OVER: begin
        players_rst = 1'b0;
      end
      default: begin
        players_rst = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl with hand-computed expectations.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [2:0] p1_btn;
  logic [2:0] p2_btn;
  logic [5:0] rand_bits;
  logic       p1_ko;
  logic       p2_ko;
  logic [2:0] p1_ctrl;
  logic [2:0] p2_ctrl;
  logic       players_rst;
  logic [2:0] state;
  logic [1:0] mode_q;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .p1_btn      (p1_btn),
    .p2_btn      (p2_btn),
    .rand_bits   (rand_bits),
    .p1_ko       (p1_ko),
    .p2_ko       (p2_ko),
    .p1_ctrl     (p1_ctrl),
    .p2_ctrl     (p2_ctrl),
    .players_rst (players_rst),
    .state       (state),
    .mode_q      (mode_q),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .winner      (winner)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle pulse on any combination of the control inputs
  task automatic applyStimulus(input logic s_start, input logic s_abort,
                               input logic s_p1ko, input logic s_p2ko, input logic [1:0] s_mode);
    start = s_start;
    abort = s_abort;
    p1_ko = s_p1ko;
    p2_ko = s_p2ko;
    mode  = s_mode;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    p1_ko = 1'b0;
    p2_ko = 1'b0;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
    end
  endtask

  task automatic idleN(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    p1_btn = 3'b101; p2_btn = 3'b010; rand_bits = 6'b0; p1_ko = 1'b0; p2_ko = 1'b0;
    idleN(2);
    reset = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_players_rst", 32'(players_rst), 1);
    checkOutput("rst_p1_ctrl", 32'(p1_ctrl), 0);
    checkOutput("rst_p2_ctrl", 32'(p2_ctrl), 0);
    checkOutput("rst_scores", 32'({p1_score, p2_score}), 0);
    checkOutput("rst_winner", 32'(winner), 0);
    checkOutput("rst_mode_q", 32'(mode_q), 0);

    // PvP match start and intro timing, with a tick gap in the middle
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("start_state", 32'(state), 1);
    checkOutput("start_mode_q", 32'(mode_q), 0);
    tickN(100);
    idleN(5);
    tickN(79);
    checkOutput("intro_179_state", 32'(state), 1);
    tickN(1);
    checkOutput("intro_180_state", 32'(state), 2);
    checkOutput("fight_players_rst", 32'(players_rst), 0);
    checkOutput("pvp_p1_ctrl", 32'(p1_ctrl), 3'b101);
    checkOutput("pvp_p2_ctrl", 32'(p2_ctrl), 3'b010);

    // P2 knocked out: P1 takes the round
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    checkOutput("ko2_p1_score", 32'(p1_score), 1);
    checkOutput("ko2_p2_score", 32'(p2_score), 0);
    checkOutput("ko2_state", 32'(state), 3);
    checkOutput("re_p1_ctrl", 32'(p1_ctrl), 0);
    checkOutput("re_players_rst", 32'(players_rst), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    checkOutput("re_ko_p1_score", 32'(p1_score), 1);
    checkOutput("re_ko_p2_score", 32'(p2_score), 0);
    tickN(119);
    checkOutput("re_119_state", 32'(state), 3);
    tickN(1);
    checkOutput("re_120_state", 32'(state), 1);

    // Double KO is a draw
    tickN(180);
    checkOutput("round2_state", 32'(state), 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    checkOutput("draw_state", 32'(state), 3);
    checkOutput("draw_p1_score", 32'(p1_score), 1);
    checkOutput("draw_p2_score", 32'(p2_score), 0);
    tickN(120);
    checkOutput("draw_next_state", 32'(state), 1);

    // Abort mid-intro keeps the score
    tickN(50);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    checkOutput("abort_intro_state", 32'(state), 0);
    checkOutput("abort_intro_p1_score", 32'(p1_score), 1);

    // PvAI match: P1 human, P2 driven by the held AI sample
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    checkOutput("pvai_mode_q", 32'(mode_q), 1);
    checkOutput("pvai_scores", 32'({p1_score, p2_score}), 0);
    tickN(180);
    checkOutput("pvai_fight", 32'(state), 2);
    rand_bits = 6'b001_000;
    p1_btn = 3'b010;
    #1;
    checkOutput("pvai_p1_ctrl", 32'(p1_ctrl), 3'b010);
    checkOutput("pvai_p2_init", 32'(p2_ctrl), 0);
    tickN(3);
    checkOutput("pvai_p2_3ticks", 32'(p2_ctrl), 0);
    tickN(1);
    checkOutput("pvai_p2_4ticks", 32'(p2_ctrl), 3'b001);
    for (int r = 1; r <= 3; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      checkOutput("pvai_round_score", 32'(p1_score), 32'(r));
      if (r < 3) begin
        tickN(120);
        tickN(180);
      end
    end
    tickN(119);
    checkOutput("final_re_state", 32'(state), 3);
    tickN(1);
    checkOutput("gameover_state", 32'(state), 4);
    checkOutput("gameover_winner", 32'(winner), 1);
    checkOutput("gameover_p1_score", 32'(p1_score), 3);
    checkOutput("gameover_players_rst", 32'(players_rst), 0);
    checkOutput("gameover_p1_ctrl", 32'(p1_ctrl), 0);

    // Restart from GAME_OVER with mode 3, which latches as PvAI
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    checkOutput("restart_state", 32'(state), 1);
    checkOutput("restart_mode_q", 32'(mode_q), 1);
    checkOutput("restart_scores", 32'({p1_score, p2_score}), 0);
    checkOutput("restart_winner", 32'(winner), 0);

    // P1 knocked out, then abort mid-fight
    tickN(180);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    checkOutput("ko1_p2_score", 32'(p2_score), 1);
    tickN(120);
    tickN(180);
    checkOutput("pre_abort_state", 32'(state), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    checkOutput("abort_fight_state", 32'(state), 0);
    checkOutput("abort_fight_p2_score", 32'(p2_score), 1);

    // AIvAI: hold filter and left+right suppression
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    checkOutput("aivai_mode_q", 32'(mode_q), 2);
    tickN(180);
    rand_bits = 6'b011_011;
    p1_btn = 3'b111;
    #1;
    checkOutput("aivai_p1_init", 32'(p1_ctrl), 0);
    tickN(4);
    checkOutput("aivai_lr_p1", 32'(p1_ctrl), 0);
    checkOutput("aivai_lr_p2", 32'(p2_ctrl), 0);
    rand_bits = 6'b100_001;
    tickN(3);
    checkOutput("aivai_hold_p1", 32'(p1_ctrl), 0);
    tickN(1);
    checkOutput("aivai_s2_p1", 32'(p1_ctrl), 3'b001);
    checkOutput("aivai_s2_p2", 32'(p2_ctrl), 3'b100);
    rand_bits = 6'b000_110;
    idleN(3);
    tickN(3);
    checkOutput("aivai_held_p1", 32'(p1_ctrl), 3'b001);
    checkOutput("aivai_held_p2", 32'(p2_ctrl), 3'b100);
    tickN(1);
    checkOutput("aivai_s3_p1", 32'(p1_ctrl), 3'b110);
    checkOutput("aivai_s3_p2", 32'(p2_ctrl), 3'b000);

    // Synchronous reset mid-fight
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    checkOutput("aivai_p1_score", 32'(p1_score), 1);
    tickN(120);
    tickN(180);
    checkOutput("pre_reset_state", 32'(state), 2);
    reset = 1'b1;
    idleN(1);
    checkOutput("mid_rst_state", 32'(state), 0);
    checkOutput("mid_rst_mode_q", 32'(mode_q), 0);
    checkOutput("mid_rst_scores", 32'({p1_score, p2_score}), 0);
    checkOutput("mid_rst_winner", 32'(winner), 0);
    checkOutput("mid_rst_players_rst", 32'(players_rst), 1);
    checkOutput("mid_rst_ctrl", 32'({p1_ctrl, p2_ctrl}), 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
